// File: rtl/lmsm_sequencer_pkg.sv
// lmsm_sequencer_pkg: shared RISC15 opcodes, LM/SM widths and sequencer state encoding
package lmsm_sequencer_pkg;
  localparam int MASK_W = 8;
  localparam int REG_W = 3;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_ADI = 4'b0001,
    OP_NDU = 4'b0010,
    OP_LHI = 4'b0011,
    OP_LW  = 4'b0100,
    OP_SW  = 4'b0101,
    OP_LM  = 4'b0110,
    OP_SM  = 4'b0111,
    OP_JAL = 4'b1000,
    OP_JLR = 4'b1001,
    OP_BEQ = 4'b1100
  } opcode_t;
  typedef enum logic {IDLE, SEQ} state_t;
endpackage

// File: rtl/lmsm_sequencer_lsb_priority_enc.sv
// lmsm_sequencer_lsb_priority_enc: lowest-set-bit index, its one-hot and a single-bit flag
module lmsm_sequencer_lsb_priority_enc import lmsm_sequencer_pkg::*; (
  input  logic [MASK_W-1:0] mask,
  output logic [REG_W-1:0]  idx,
  output logic [MASK_W-1:0] one_hot,
  output logic              single_bit
);
  always_comb begin
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) idx = mask[i] ? REG_W'(i) : idx;
  end
  assign one_hot = mask & (~mask + 1'b1);
  assign single_bit = (mask != '0) && ((mask & (mask - 1'b1)) == '0);
endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM in pr2 into one single-register micro-op per cycle into pr3
module lmsm_sequencer import lmsm_sequencer_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      pr2_IR,
  input  logic             pr2_valid,
  input  logic             hold,
  input  logic             flush,
  output logic             fetch_stall,
  output logic             bubble,
  output logic             uop_valid,
  output logic             uop_is_lm,
  output logic [REG_W-1:0] uop_reg,
  output logic [REG_W-1:0] uop_offset,
  output logic             uop_first,
  output logic             uop_last,
  output logic             busy
);
  state_t state;
  logic [MASK_W-1:0] mask, low_bit;
  logic [REG_W-1:0] offset, low_idx;
  logic is_lm, single, detect, start, seq, unused_ra;
  logic [3:0] op;
  assign op = pr2_IR[15:12];
  assign unused_ra = ^pr2_IR[11:8];
  assign detect = pr2_valid && (op == OP_LM || op == OP_SM) && pr2_IR[MASK_W-1:0] != '0 && !flush;
  assign start = state == IDLE && detect && !reset;
  assign seq = state == SEQ && !flush && !reset;
  assign busy = state == SEQ;
  lmsm_sequencer_lsb_priority_enc u_enc (
    .mask(mask),
    .idx(low_idx),
    .one_hot(low_bit),
    .single_bit(single)
  );
  always_comb begin
    uop_valid = seq;
    uop_is_lm = seq && is_lm;
    uop_reg = seq ? low_idx : '0;
    uop_offset = seq ? offset : '0;
    uop_first = seq && offset == '0;
    uop_last = seq && single;
    bubble = start;
    fetch_stall = start || (seq && (!single || hold));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      offset <= '0;
      is_lm <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      mask <= '0;
      offset <= '0;
    end else if (state == IDLE) begin
      if (detect && !hold) begin
        state <= SEQ;
        mask <= pr2_IR[MASK_W-1:0];
        is_lm <= op == OP_LM;
        offset <= '0;
      end
    end else if (!hold) begin
      // last uop releases pr2 on this same edge, so the next instruction sees IDLE immediately
      if (single) begin
        state <= IDLE;
        mask <= '0;
        offset <= '0;
      end else begin
        mask <= mask & ~low_bit;
        offset <= offset + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: scoreboard bench, per-cycle expected output vectors queued by the driver
module tb_lmsm_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] pr2_IR = '0;
  logic pr2_valid = 1'b0, hold = 1'b0, flush = 1'b0;
  logic fetch_stall, bubble, uop_valid, uop_is_lm, uop_first, uop_last, busy;
  logic [2:0] uop_reg, uop_offset;
  logic [12:0] got;
  logic [12:0] exp_q[$];
  string tag = "init";
  int tests = 0, fails = 0;

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .pr2_IR(pr2_IR), .pr2_valid(pr2_valid), .hold(hold), .flush(flush),
    .fetch_stall(fetch_stall), .bubble(bubble), .uop_valid(uop_valid), .uop_is_lm(uop_is_lm),
    .uop_reg(uop_reg), .uop_offset(uop_offset), .uop_first(uop_first), .uop_last(uop_last), .busy(busy)
  );

  always #5 clk = ~clk;
  assign got = {busy, fetch_stall, bubble, uop_valid, uop_is_lm, uop_reg, uop_offset, uop_first, uop_last};

  task automatic check(input string t, input logic [12:0] act, input logic [12:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0t: got busy/fs/bub/v/lm/reg/off/first/last=%b required %b", t, $time, act, req);
    end
  endtask

  function automatic logic [12:0] pack(input bit b, fs, bub, v, lm, input logic [2:0] r, o, input bit fi, la);
    return {b, fs, bub, v, lm, r, o, fi, la};
  endfunction

  always @(negedge clk) if (exp_q.size() != 0) check(tag, got, exp_q.pop_front());

  task automatic step(input logic [15:0] ir, input logic v, h, f, input logic [12:0] e);
    pr2_IR = ir; pr2_valid = v; hold = h; flush = f;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // hd: hold cycles at detect; hu/hn: hold hn cycles on uop hu; fu: flush on uop fu (-1 = none)
  task automatic run(input string t, input logic [15:0] ir, input int hd, hu, hn, fu);
    logic [2:0] regs[$];
    bit lm, last;
    tag = t;
    lm = ir[15:12] == 4'b0110;
    for (int i = 0; i < 8; i++) if (ir[i]) regs.push_back(3'(i));
    if (regs.size() == 0) begin
      step(ir, 1, 0, 0, '0);
      return;
    end
    repeat (hd) step(ir, 1, 1, 0, pack(0, 1, 1, 0, 0, 0, 0, 0, 0));
    step(ir, 1, 0, 0, pack(0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < regs.size(); k++) begin
      last = k == regs.size() - 1;
      if (k == fu) begin
        step(ir, 1, 1, 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(16'h0000, 0, 0, 0, '0);
        return;
      end
      if (k == hu) repeat (hn) step(ir, 1, 1, 0, pack(1, 1, 0, 1, lm, regs[k], 3'(k), k == 0, last));
      step(ir, 1, 0, 0, pack(1, !last, 0, 1, lm, regs[k], 3'(k), k == 0, last));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    pr2_IR = 16'h6085; pr2_valid = 1'b1;
    #3 check("reset_outputs", got, '0);
    @(posedge clk); #1;
    reset = 1'b0; pr2_valid = 1'b0;
    tag = "idle"; step(16'h0000, 0, 0, 0, '0);
    run("lm_85", 16'h6085, 0, -1, 0, -1);
    tag = "gap1"; step(16'h0000, 0, 0, 0, '0);
    run("sm_00", 16'h7000, 0, -1, 0, -1);
    run("sm_ff", 16'h70FF, 0, -1, 0, -1);
    run("lm_06_hold", 16'h6006, 0, 1, 3, -1);
    run("sm_0a_hold_detect", 16'h730A, 2, 0, 1, -1);
    run("lm_0f_flush", 16'h600F, 0, -1, 0, 1);
    run("b2b_lm_01", 16'h6001, 0, -1, 0, -1);
    run("b2b_sm_02", 16'h7002, 0, -1, 0, -1);
    tag = "flush_detect"; step(16'h6003, 1, 0, 1, '0);
    tag = "mask0_lm"; step(16'h6500, 1, 0, 0, '0);
    tag = "rst_mid";
    step(16'h600F, 1, 0, 0, pack(0, 1, 1, 0, 0, 0, 0, 0, 0));
    step(16'h600F, 1, 0, 0, pack(1, 1, 0, 1, 1, 0, 0, 1, 0));
    #1 reset = 1'b1;
    #1 check("rst_mid_async", got, '0);
    @(posedge clk); #1;
    reset = 1'b0; pr2_valid = 1'b0;
    tag = "after_rst"; step(16'h0000, 0, 0, 0, '0);
    run("lm_80_after_rst", 16'h6180, 0, -1, 0, -1);
    tag = "end"; step(16'h0000, 0, 0, 0, '0);
    check("drain", 13'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
